// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: accepts one load/store, answers LATENCY cycles later.
// Optional address checking (misaligned / out-of-range -> rsp_err) enabled by DMEM_ERR_CHECK_EN.
module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  input  logic [3:0]  req_tag,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [3:0]  rsp_tag,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [3:0]  tag_q;

  logic [31:0] mem [DEPTH];

  logic [AW-1:0] idx;
  logic          err;
  logic          access;
  logic          mem_wr;
  logic          unused_addr_bits;

  assign req_ready = (state == IDLE);
  assign idx       = addr_q[AW+1:2];

`ifdef DMEM_ERR_CHECK_EN
  assign err = (addr_q[1:0] != 2'b00) || (addr_q >= 32'(DEPTH * 4));
`else
  assign err = 1'b0;
`endif

  // Without address checking the upper and low-order address bits are don't-care.
  assign unused_addr_bits = &{1'b0, addr_q};

  assign access = (state == WAIT) && (cnt == 4'd0);
  assign mem_wr = access && we_q && !err;

  // Memory is not reset; an async reset in WAIT leaves state IDLE before the access edge.
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      we_q      <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      be_q      <= 4'd0;
      tag_q     <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_tag   <= 4'd0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
            tag_q   <= req_tag;
            cnt     <= 4'(LATENCY - 1);
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_tag   <= tag_q;
            rsp_err   <= err;
            rsp_rdata <= (we_q || err) ? 32'd0 : mem[idx];
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning the number of 32-bit memory words (power of two).
REQ-002 SHALL have parameter LATENCY, default 2, meaning the number of cycles from request acceptance to response valid (legal range 1..15).
REQ-003 SHALL use one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 req_valid  input  1  the CPU load/store unit presents a request.
REQ-007 req_ready  output  1  the responder accepts a request this cycle.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data.
REQ-011 req_be  input  4  store byte enables; bit i covers bits [8i+7:8i].
REQ-012 req_tag  input  4  request identifier, returned unchanged.
REQ-013 rsp_valid  output  1  response presented.
REQ-014 rsp_ready  input  1  the CPU accepts the response.
REQ-015 rsp_rdata  output  32  load data; 0 for stores and errors.
REQ-016 rsp_tag  output  4  tag of the request being answered.
REQ-017 rsp_err  output  1  the request was misaligned or out of range.

Function
REQ-018 SHALL implement an FSM with states IDLE, WAIT and RESP, and SHALL allow one outstanding request.
REQ-019 SHALL drive req_ready=1 only in IDLE, combinationally from state and independent of req_valid.
REQ-020 SHALL, in IDLE on a clock edge with req_valid&&req_ready, latch we/addr/wdata/be/tag, load the counter with LATENCY-1, and enter WAIT.
REQ-021 SHALL decrement the counter each cycle in WAIT; at the edge where the counter equals 0 it SHALL perform the memory access and enter RESP.
REQ-022 SHALL assert rsp_valid first in the cycle after edge N+LATENCY, where N is the acceptance edge.
REQ-023 SHALL, for a load, return the full word at word index addr[log2(DEPTH)+1:2], ignoring be.
REQ-024 SHALL, for a store, write only the bytes whose be bit is 1 and return rsp_rdata=0; be=0 is a legal no-op store.
REQ-025 SHALL hold rsp_valid, rsp_rdata, rsp_tag and rsp_err stable in RESP until rsp_ready=1.
REQ-026 SHALL return to IDLE on the edge where rsp_valid&&rsp_ready, clear rsp_valid, and assert req_ready in the next cycle; there is no same-cycle response-to-request overlap.
REQ-027 SHALL ignore req_valid while in WAIT or RESP.
REQ-028 SHALL make a load issued after a store to the same word return the post-store data.

Reset
REQ-029 SHALL, while rst=1, force state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_tag=0 and rsp_err=0, without waiting for a clock edge.
REQ-030 SHALL drop an in-flight request on reset asserted in WAIT: no memory write and no response occur.
REQ-031 SHALL not clear memory contents on reset; contents are undefined at power-up and retained across reset.
REQ-032 SHALL present req_ready=1 in the first cycle after rst deasserts.

Configuration
REQ-033 SHALL use macro DMEM_ERR_CHECK_EN.
REQ-034 SHALL, with DMEM_ERR_CHECK_EN defined, set rsp_err=1 for requests where addr[1:0]!=0 or addr>=DEPTH*4; such requests perform no write, return rsp_rdata=0, and keep the same latency.
REQ-035 SHALL, with DMEM_ERR_CHECK_EN undefined, tie rsp_err to 0, ignore addr[1:0], and wrap the address modulo DEPTH words.

Verification
REQ-036 Reset then store addr=0x10 wdata=0xDEADBEEF be=0xF tag=3 at edge N -> rsp_valid at N+2, rsp_tag=3, rsp_rdata=0, rsp_err=0.
REQ-037 Load 0x10 tag=5 after REQ-036 -> rsp_rdata=0xDEADBEEF, tag=5; store be=0x3 wdata=0x00001234, then load -> 0xDEAD1234.
REQ-038 Hold rsp_ready=0 for 5 cycles during a response -> rsp_valid/rdata/tag remain stable, req_ready=0; on release, req_ready=1 in the next cycle.
REQ-039 Assert rst in WAIT of a store to 0x20 (wdata=0x55) -> no response, and a later load of 0x20 returns the prior value.
REQ-040 With DMEM_ERR_CHECK_EN: load addr=0x13 or addr=0x400 (DEPTH=256) -> rsp_err=1, rdata=0; without it, addr=0x400 loads word 0.
